// File: rtl/axi_ni_resp_tracker_pkg.sv
// Shared constants for the NI response tracker: FSM encodings and accept-vector width.
package axi_ni_resp_tracker_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE            = 3'd0;
    localparam logic [STATE_W-1:0] ST_FILL_HEADER     = 3'd1;
    localparam logic [STATE_W-1:0] ST_CHECK_ID        = 3'd2;
    localparam logic [STATE_W-1:0] ST_FILL_PAYLOAD    = 3'd3;
    localparam logic [STATE_W-1:0] ST_PAYLOAD_TX      = 3'd4;
    localparam logic [STATE_W-1:0] ST_LAST_PAYLOAD_TX = 3'd5;
    localparam logic [STATE_W-1:0] ST_DROP            = 3'd6;

    // One bit per response channel: {R accepted, B accepted}.
    localparam int ACCEPT_W   = 2;
    localparam int ACC_R_BIT  = 1;
    localparam int ACC_B_BIT  = 0;

endpackage

// File: rtl/axi_ni_outs_counter.sv
// Saturating up/down outstanding-burst counter with a nonzero flag.
module axi_ni_outs_counter #(
    parameter int CNT_W = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output logic busy_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Simultaneous inc/dec cancel; ends of range hold instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i && !(&cnt_q))
            cnt_d = cnt_q + 1'b1;
        else if (dec_i && !inc_i && (|cnt_q))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign busy_o = |cnt_q;

endmodule

// File: rtl/axi_ni_resp_tracker.sv
// Tracks outstanding AXI bursts per ID and steers incoming NI response packets to R/B or drops them.
module axi_ni_resp_tracker
    import axi_ni_resp_tracker_pkg::*;
#(
    parameter int MAX_SUPPORTED_IDS = 16,
    parameter int ID_WIDTH          = 4,
    parameter int OUTS_CNT_WIDTH    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         full_header,
    input  logic                         full_payload,
    input  logic                         packet_finished,
    input  logic                         packet_type_is_read,
    input  logic [ID_WIDTH-1:0]          received_id,
    input  logic                         BREADY,
    input  logic                         RREADY,
    input  logic [MAX_SUPPORTED_IDS-1:0] incr_outs_wr,
    input  logic [MAX_SUPPORTED_IDS-1:0] incr_outs_rd,
    output logic                         receiving_header,
    output logic                         receiving_payload,
    output logic                         processing_response,
    output logic                         mask_response,
    output logic                         clear_flit_count,
    output logic                         transaction_complete,
    output logic                         RLAST,
    output logic [MAX_SUPPORTED_IDS-1:0] outs_wr_busy,
    output logic [MAX_SUPPORTED_IDS-1:0] outs_rd_busy,
    output logic                         unexpected_resp
);

    logic [STATE_W-1:0]           state_q, state_d;
    logic [ACCEPT_W-1:0]          accept_vec;
    logic                         accept;
    logic                         sel_busy;
    logic                         dec_fire;
    logic [MAX_SUPPORTED_IDS-1:0] dec_wr, dec_rd;

    assign accept_vec[ACC_R_BIT] = RREADY &  packet_type_is_read;
    assign accept_vec[ACC_B_BIT] = BREADY & ~packet_type_is_read;
    assign accept                = |accept_vec;
    assign dec_fire              = (state_q == ST_LAST_PAYLOAD_TX) && accept;

    // IDs beyond the tracked range never match, so they read as zero-count and get dropped.
    always_comb begin
        sel_busy = 1'b0;
        dec_wr   = '0;
        dec_rd   = '0;
        for (int i = 0; i < MAX_SUPPORTED_IDS; i++) begin
            if (received_id == ID_WIDTH'(i)) begin
                sel_busy  = packet_type_is_read ? outs_rd_busy[i] : outs_wr_busy[i];
                dec_rd[i] = dec_fire &  packet_type_is_read;
                dec_wr[i] = dec_fire & ~packet_type_is_read;
            end
        end
    end

    for (genvar g = 0; g < MAX_SUPPORTED_IDS; g++) begin : g_cnt
        axi_ni_outs_counter #(.CNT_W(OUTS_CNT_WIDTH)) u_wr (
            .clk    (clk),
            .rst_n  (rst),
            .inc_i  (incr_outs_wr[g]),
            .dec_i  (dec_wr[g]),
            .busy_o (outs_wr_busy[g])
        );
        axi_ni_outs_counter #(.CNT_W(OUTS_CNT_WIDTH)) u_rd (
            .clk    (clk),
            .rst_n  (rst),
            .inc_i  (incr_outs_rd[g]),
            .dec_i  (dec_rd[g]),
            .busy_o (outs_rd_busy[g])
        );
    end

    always_comb begin
        state_d              = state_q;
        receiving_header     = 1'b0;
        receiving_payload    = 1'b0;
        processing_response  = 1'b0;
        mask_response        = 1'b0;
        clear_flit_count     = 1'b0;
        transaction_complete = 1'b0;
        RLAST                = 1'b0;
        unexpected_resp      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mask_response    = 1'b1;
                clear_flit_count = 1'b1;
                if (|{outs_wr_busy, outs_rd_busy}) state_d = ST_FILL_HEADER;
            end
            ST_FILL_HEADER: begin
                receiving_header    = 1'b1;
                processing_response = 1'b1;
                mask_response       = 1'b1;
                if (full_header) state_d = ST_CHECK_ID;
            end
            ST_CHECK_ID: begin
                receiving_header    = 1'b1;
                processing_response = 1'b1;
                mask_response       = 1'b1;
                if (sel_busy) begin
                    state_d = ST_FILL_PAYLOAD;
                end else begin
                    state_d         = ST_DROP;
                    unexpected_resp = 1'b1;
                end
            end
            ST_FILL_PAYLOAD: begin
                receiving_payload   = 1'b1;
                processing_response = 1'b1;
                mask_response       = 1'b1;
                if (packet_finished)   state_d = ST_LAST_PAYLOAD_TX;
                else if (full_payload) state_d = ST_PAYLOAD_TX;
            end
            ST_PAYLOAD_TX: begin
                // Intermediate flits of a write response never reach the B channel.
                processing_response = 1'b1;
                clear_flit_count    = 1'b1;
                mask_response       = ~packet_type_is_read;
                if (accept) state_d = ST_FILL_PAYLOAD;
            end
            ST_LAST_PAYLOAD_TX: begin
                processing_response  = 1'b1;
                clear_flit_count     = 1'b1;
                RLAST                = packet_type_is_read;
                transaction_complete = accept;
                if (accept) state_d = ST_IDLE;
            end
            ST_DROP: begin
                receiving_payload = 1'b1;
                mask_response     = 1'b1;
                clear_flit_count  = 1'b1;
                if (packet_finished) state_d = ST_IDLE;
            end
            default: begin
                mask_response    = 1'b1;
                clear_flit_count = 1'b1;
                state_d          = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

endmodule

// File: tb/tb_axi_ni_resp_tracker.sv
// Scoreboard bench: driver pushes expected R/B beats and drops, monitor pops on every observed event.
module tb_axi_ni_resp_tracker;

    localparam int NIDS = 12;
    localparam int IDW  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int EV_DROP = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            full_header = 1'b0, full_payload = 1'b0, packet_finished = 1'b0;
    logic            packet_type_is_read = 1'b0;
    logic [IDW-1:0]  received_id = '0;
    logic            BREADY = 1'b0, RREADY = 1'b0;
    logic [NIDS-1:0] incr_outs_wr = '0, incr_outs_rd = '0;
    logic            receiving_header, receiving_payload, processing_response, mask_response;
    logic            clear_flit_count, transaction_complete, RLAST, unexpected_resp;
    logic [NIDS-1:0] outs_wr_busy, outs_rd_busy;

    always #5 clk = ~clk;

    axi_ni_resp_tracker #(
        .MAX_SUPPORTED_IDS (NIDS),
        .ID_WIDTH          (IDW),
        .OUTS_CNT_WIDTH    (CW)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .full_header          (full_header),
        .full_payload         (full_payload),
        .packet_finished      (packet_finished),
        .packet_type_is_read  (packet_type_is_read),
        .received_id          (received_id),
        .BREADY               (BREADY),
        .RREADY               (RREADY),
        .incr_outs_wr         (incr_outs_wr),
        .incr_outs_rd         (incr_outs_rd),
        .receiving_header     (receiving_header),
        .receiving_payload    (receiving_payload),
        .processing_response  (processing_response),
        .mask_response        (mask_response),
        .clear_flit_count     (clear_flit_count),
        .transaction_complete (transaction_complete),
        .RLAST                (RLAST),
        .outs_wr_busy         (outs_wr_busy),
        .outs_rd_busy         (outs_rd_busy),
        .unexpected_resp      (unexpected_resp)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];
    int cnt_wr[NIDS];
    int cnt_rd[NIDS];
    int rdy_mode = 0;  // 0 random, 1 both high, 2 BREADY low

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0: header phase, 1: payload phase (FILL_PAYLOAD or DROP), 2: idle
    task automatic wait_for(input int which);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 300) begin
            @(negedge clk);
            n++;
            case (which)
                0:       hit = receiving_header;
                1:       hit = receiving_payload;
                default: hit = !processing_response && !receiving_payload;
            endcase
        end
        if (!hit) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_%0d: condition not seen within %0d cycles", which, n);
        end
    endtask

    function automatic logic [NIDS-1:0] model_busy(input bit rd);
        logic [NIDS-1:0] v;
        for (int i = 0; i < NIDS; i++) v[i] = rd ? (cnt_rd[i] != 0) : (cnt_wr[i] != 0);
        return v;
    endfunction

    function automatic int model_total();
        int t;
        t = 0;
        for (int i = 0; i < NIDS; i++) t += cnt_wr[i] + cnt_rd[i];
        return t;
    endfunction

    task automatic model_inc(input bit rd, input int id);
        if (rd) cnt_rd[id] = (cnt_rd[id] >= CMAX) ? CMAX : cnt_rd[id] + 1;
        else    cnt_wr[id] = (cnt_wr[id] >= CMAX) ? CMAX : cnt_wr[id] + 1;
    endtask

    task automatic check_busy(input string tag);
        chk({tag, "_wr_busy"}, 32'(outs_wr_busy), 32'(model_busy(1'b0)));
        chk({tag, "_rd_busy"}, 32'(outs_rd_busy), 32'(model_busy(1'b1)));
    endtask

    task automatic incr(input bit rd, input int id);
        tick();
        if (rd) incr_outs_rd[id] = 1'b1;
        else    incr_outs_wr[id] = 1'b1;
        tick();
        incr_outs_rd = '0;
        incr_outs_wr = '0;
        model_inc(rd, id);
    endtask

    // A response packet of 'beats' flits. hold>0 keeps BREADY low that many cycles at the last flit;
    // coinc>=0 issues a same-type increment to that ID in the cycle of the final accept.
    task automatic send_pkt(input bit rd, input int id, input int beats, input int hold, input int coinc);
        bit ok;
        ok = (id < NIDS) && ((rd ? cnt_rd[id % NIDS] : cnt_wr[id % NIDS]) > 0);
        if (!ok)     exp_q.push_back(EV_DROP);
        else if (rd) for (int k = 0; k < beats; k++) exp_q.push_back((k == beats - 1) ? 7 : 4);
        else         exp_q.push_back(1);

        wait_for(0);
        tick();
        packet_type_is_read = rd;
        received_id = IDW'(id);
        repeat ($urandom_range(0, 2)) tick();
        full_header = 1'b1;
        tick();
        full_header = 1'b0;

        if (!ok) begin
            wait_for(1);
            tick();
            repeat ($urandom_range(0, 3)) tick();
            packet_finished = 1'b1;
            tick();
            packet_finished = 1'b0;
        end else begin
            for (int k = 0; k < beats; k++) begin
                wait_for(1);
                tick();
                repeat ($urandom_range(0, 2)) tick();
                if (k == beats - 1) packet_finished = 1'b1;
                else                full_payload = 1'b1;
                tick();
                packet_finished = 1'b0;
                full_payload = 1'b0;
                if (k == beats - 1 && coinc >= 0) begin
                    if (rd) incr_outs_rd[coinc] = 1'b1;
                    else    incr_outs_wr[coinc] = 1'b1;
                    model_inc(rd, coinc);
                    tick();
                    incr_outs_rd = '0;
                    incr_outs_wr = '0;
                end
            end
            if (hold > 0) begin
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    chk("hold_tc", 32'(transaction_complete), 32'd0);
                    chk("hold_state", 32'(processing_response && clear_flit_count && !receiving_payload
                                          && !receiving_header), 32'd1);
                end
                @(posedge clk);
                #1;
                rdy_mode = 1;
                BREADY = 1'b1;
            end
        end
        wait_for(2);
        if (ok) begin
            if (rd) cnt_rd[id] = cnt_rd[id] - 1;
            else    cnt_wr[id] = cnt_wr[id] - 1;
        end
        check_busy(rd ? "rd_pkt" : "wr_pkt");
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1: begin RREADY = 1'b1; BREADY = 1'b1; end
                2: begin RREADY = ($urandom_range(0, 3) != 0); BREADY = 1'b0; end
                default: begin
                    RREADY = ($urandom_range(0, 3) != 0);
                    BREADY = ($urandom_range(0, 3) != 0);
                end
            endcase
        end
    end

    task automatic pop_cmp(input int ev);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL event: got %0d expected none (t=%0t)", ev, $time);
        end else begin
            chk("event", 32'(ev), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        bit acc;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (unexpected_resp) pop_cmp(EV_DROP);
                if (processing_response && !mask_response) begin
                    acc = packet_type_is_read ? RREADY : BREADY;
                    if (acc) pop_cmp({29'd0, packet_type_is_read, RLAST, transaction_complete});
                    else     chk("tc_no_accept", 32'(transaction_complete), 32'd0);
                end
                if (receiving_payload && !processing_response)
                    chk("drop_masked", 32'(mask_response), 32'd1);
            end
        end
    end

    initial begin
        int ids[$];
        int id;
        bit rd;
        for (int i = 0; i < NIDS; i++) begin cnt_wr[i] = 0; cnt_rd[i] = 0; end

        #2;
        chk("rst_outputs", {25'd0, receiving_header, receiving_payload, processing_response,
                            mask_response, clear_flit_count, transaction_complete, RLAST}, 32'h0C);
        chk("rst_unexp", 32'(unexpected_resp), 32'd0);
        check_busy("rst");
        @(negedge clk);
        rst = 1'b1;

        // 4-beat read on id 3
        rdy_mode = 1;
        incr(1'b1, 3);
        check_busy("inc3");
        send_pkt(1'b1, 3, 4, 0, -1);

        // write to untracked id 5 is dropped while something else keeps the FSM awake
        incr(1'b1, 7);
        send_pkt(1'b0, 5, 1, 0, -1);
        send_pkt(1'b1, 7, 1, 0, -1);

        // out-of-range id is dropped even though id 2 is busy
        incr(1'b0, 2);
        send_pkt(1'b0, 13, 1, 0, -1);
        send_pkt(1'b0, 2, 2, 0, -1);

        // B channel back-pressure on the last flit
        incr(1'b0, 4);
        rdy_mode = 2;
        send_pkt(1'b0, 4, 1, 10, -1);
        rdy_mode = 1;

        // increment coincident with final accept leaves count at 1
        incr(1'b1, 2);
        send_pkt(1'b1, 2, 2, 0, 2);
        send_pkt(1'b1, 2, 1, 0, -1);

        // saturation: 16 increments, 15 responses empty the counter
        rdy_mode = 0;
        for (int i = 0; i < 16; i++) incr(1'b1, 0);
        check_busy("sat");
        for (int i = 0; i < 15; i++) send_pkt(1'b1, 0, 1, 0, -1);

        // asynchronous reset mid-payload
        incr(1'b1, 1);
        incr(1'b0, 6);
        wait_for(0);
        tick();
        packet_type_is_read = 1'b1;
        received_id = IDW'(1);
        full_header = 1'b1;
        tick();
        full_header = 1'b0;
        wait_for(1);
        #2;
        rst = 1'b0;
        for (int i = 0; i < NIDS; i++) begin cnt_wr[i] = 0; cnt_rd[i] = 0; end
        #1;
        chk("async_rst_outputs", {25'd0, receiving_header, receiving_payload, processing_response,
                                  mask_response, clear_flit_count, transaction_complete, RLAST}, 32'h0C);
        check_busy("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // randomized traffic
        for (int it = 0; it < 60; it++) begin
            if (model_total() == 0 || $urandom_range(0, 2) == 0) begin
                incr(1'($urandom_range(0, 1)), $urandom_range(0, NIDS - 1));
            end else begin
                rd = 1'($urandom_range(0, 1));
                ids.delete();
                for (int i = 0; i < NIDS; i++)
                    if ((rd ? cnt_rd[i] : cnt_wr[i]) > 0) ids.push_back(i);
                if (ids.size() > 0 && $urandom_range(0, 3) != 0)
                    id = ids[$urandom_range(0, ids.size() - 1)];
                else
                    id = $urandom_range(0, (1 << IDW) - 1);
                send_pkt(rd, id, rd ? $urandom_range(1, 4) : $urandom_range(1, 2), 0, -1);
            end
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
